// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: one word fetch per
// instruction from a variable-latency imem, one-entry stall buffer, flush squash.
module if_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        halt,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid_id,
  output logic [31:0] instr_id,
  output logic [31:0] pc_if_id,
  output logic        fetch_busy,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic        flush_pend_q, flush_pend_d;

  logic        kill_ack;
  logic        deliver;
  logic [31:0] dlv_word, dlv_addr;

  // A flush seen earlier in WAIT still kills the word when it finally arrives.
  assign kill_ack = flush | flush_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      count_q      <= '0;
      buf_word_q   <= '0;
      buf_addr_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      buf_word_q   <= buf_word_d;
      buf_addr_q   <= buf_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!halt && !flush) state_d = S_WAIT;
      S_WAIT: if (imem_ack) begin
        if (kill_ack)   state_d = S_IDLE;
        else if (stall) state_d = S_HOLD;
        else            state_d = S_IDLE;
      end
      S_HOLD: if (flush || !stall) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d        = req_q;
    addr_d       = addr_q;
    buf_word_d   = buf_word_q;
    buf_addr_d   = buf_addr_q;
    flush_pend_d = flush_pend_q;
    deliver      = 1'b0;
    dlv_word     = imem_rdata;
    dlv_addr     = addr_q;
    unique case (state_q)
      S_IDLE: if (!halt && !flush) begin
        req_d  = 1'b1;
        addr_d = pc_in;
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_d        = 1'b0;
          flush_pend_d = 1'b0;
          if (!kill_ack) begin
            if (stall) begin
              buf_word_d = imem_rdata;
              buf_addr_d = addr_q;
            end else begin
              deliver = 1'b1;
            end
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      S_HOLD: if (!flush && !stall) begin
        deliver  = 1'b1;
        dlv_word = buf_word_q;
        dlv_addr = buf_addr_q;
      end
      default: ;
    endcase

    // IF/ID priority: flush > stall > deliver > bubble
    valid_d = 1'b0;
    instr_d = NOP_INSTR;
    pc_d    = pc_q;
    count_d = count_q;
    if (!flush) begin
      if (stall) begin
        valid_d = valid_q;
        instr_d = instr_q;
      end else if (deliver) begin
        valid_d = 1'b1;
        instr_d = dlv_word;
        pc_d    = dlv_addr;
        count_d = count_q + 32'd1;
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign valid_id    = valid_q;
  assign instr_id    = instr_q;
  assign pc_if_id    = pc_q;
  assign fetch_count = count_q;
  assign fetch_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: auto-responding imem with programmable latency
// plus manual ack control for flush/stall/reset corner cases.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, halt, stall, flush;
  logic [31:0] pc_in;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        valid_id, fetch_busy;
  logic [31:0] instr_id, pc_if_id, fetch_count;

  logic        resp_en = 1'b0;
  int          lat = 1;
  int          rcnt = 0;
  logic        auto_ack = 1'b0, man_ack = 1'b0;
  logic [31:0] auto_rdata = '0, man_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  assign imem_ack   = resp_en ? auto_ack   : man_ack;
  assign imem_rdata = resp_en ? auto_rdata : man_rdata;

  always #5 clk = ~clk;

  if_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .halt(halt), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .valid_id(valid_id), .instr_id(instr_id), .pc_if_id(pc_if_id),
    .fetch_busy(fetch_busy), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // ack after req has been high for lat cycles
  always @(negedge clk) begin
    auto_ack <= 1'b0;
    if (resp_en && imem_req) begin
      if (rcnt + 1 >= lat) begin
        auto_ack   <= 1'b1;
        auto_rdata <= mem(imem_addr);
        rcnt       <= 0;
      end else begin
        rcnt <= rcnt + 1;
      end
    end else begin
      rcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; halt = 1'b1; stall = 1'b0; flush = 1'b0; pc_in = '0;
    cyc(2);
    check("rst_req",   {31'b0, imem_req},   32'd0);
    check("rst_valid", {31'b0, valid_id},   32'd0);
    check("rst_instr", instr_id,            NOP);
    check("rst_pc",    pc_if_id,            32'd0);
    check("rst_count", fetch_count,         32'd0);
    check("rst_busy",  {31'b0, fetch_busy}, 32'd0);
    rst = 1'b0;
    cyc(3);
    check("halt_noreq", {31'b0, imem_req}, 32'd0);

    // zero-wait memory, sequential PCs
    resp_en = 1'b1; lat = 1; halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_in = i;
      cyc(1);
      for (int k = 0; k < 10 && !valid_id; k++) cyc(1);
      check("zw_valid", {31'b0, valid_id}, 32'd1);
      check("zw_instr", instr_id, mem(i));
      check("zw_pc",    pc_if_id, i);
      if (i == 2) halt = 1'b1;
    end
    check("zw_count", fetch_count, 32'd3);
    cyc(1);
    check("zw_bubble", {31'b0, valid_id}, 32'd0);

    // 3-cycle latency
    lat = 3; pc_in = 32'd5; halt = 1'b0;
    cyc(1);
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("lat_req",   {31'b0, imem_req}, 32'd1);
      check("lat_addr",  imem_addr,         32'd5);
      check("lat_valid", {31'b0, valid_id}, 32'd0);
      cyc(1);
    end
    check("lat_dvalid", {31'b0, valid_id}, 32'd1);
    check("lat_instr",  instr_id,          mem(5));
    check("lat_pc",     pc_if_id,          32'd5);
    check("lat_count",  fetch_count,       32'd4);
    resp_en = 1'b0;
    cyc(1);

    // stall on ack cycle -> HOLD, then release
    pc_in = 32'd8; halt = 1'b0;
    cyc(1);
    halt = 1'b1; man_ack = 1'b1; man_rdata = mem(8); stall = 1'b1;
    cyc(1);
    man_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("st_busy",  {31'b0, fetch_busy}, 32'd1);
      check("st_valid", {31'b0, valid_id},   32'd0);
      check("st_pc",    pc_if_id,            32'd5);
      if (k < 3) cyc(1);
    end
    check("st_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    cyc(1);
    check("st_dvalid", {31'b0, valid_id},   32'd1);
    check("st_instr",  instr_id,            mem(8));
    check("st_dpc",    pc_if_id,            32'd8);
    check("st_count",  fetch_count,         32'd5);
    check("st_idle",   {31'b0, fetch_busy}, 32'd0);

    // flush in WAIT one cycle before ack
    pc_in = 32'd12; halt = 1'b0;
    cyc(1);
    halt = 1'b1; flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    check("fl_reqheld", {31'b0, imem_req}, 32'd1);
    check("fl_valid0",  {31'b0, valid_id}, 32'd0);
    man_ack = 1'b1; man_rdata = mem(12);
    cyc(1);
    man_ack = 1'b0;
    check("fl_req",   {31'b0, imem_req},   32'd0);
    check("fl_busy",  {31'b0, fetch_busy}, 32'd0);
    check("fl_valid", {31'b0, valid_id},   32'd0);
    check("fl_instr", instr_id,            NOP);
    check("fl_pc",    pc_if_id,            32'd8);
    check("fl_count", fetch_count,         32'd5);
    cyc(1);
    check("fl_valid2", {31'b0, valid_id}, 32'd0);

    // flush and stall together in HOLD
    pc_in = 32'd20; halt = 1'b0;
    cyc(1);
    halt = 1'b1; man_ack = 1'b1; man_rdata = mem(20); stall = 1'b1;
    cyc(1);
    man_ack = 1'b0;
    check("fs_hold", {31'b0, fetch_busy}, 32'd1);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0; stall = 1'b0;
    check("fs_busy",  {31'b0, fetch_busy}, 32'd0);
    check("fs_valid", {31'b0, valid_id},   32'd0);
    cyc(1);
    check("fs_valid2", {31'b0, valid_id}, 32'd0);
    check("fs_count",  fetch_count,       32'd5);
    check("fs_pc",     pc_if_id,          32'd8);

    // reset mid-WAIT, late ack ignored
    pc_in = 32'd30; halt = 1'b0;
    cyc(1);
    check("rw_req1", {31'b0, imem_req}, 32'd1);
    halt = 1'b1; rst = 1'b1;
    cyc(1);
    rst = 1'b0; man_ack = 1'b1; man_rdata = mem(30);
    check("rw_req",   {31'b0, imem_req}, 32'd0);
    check("rw_count", fetch_count,       32'd0);
    cyc(1);
    man_ack = 1'b0;
    check("rw_valid", {31'b0, valid_id},   32'd0);
    check("rw_busy",  {31'b0, fetch_busy}, 32'd0);
    check("rw_cnt2",  fetch_count,         32'd0);
    check("rw_req2",  {31'b0, imem_req},   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
